// File: rtl/queue_rr_arbiter.sv
// Round-robin arbiter sharing one val/rdy output among p_num_reqs requesters,
// with grant locking for bursts of up to p_burst_max messages and a one-entry pipe output register.
module queue_rr_arbiter #(
   parameter int p_num_reqs  = 4,
   parameter int p_msg_nbits = 32,
   parameter int p_burst_max = 4,
   localparam int c_src_nbits = $clog2(p_num_reqs)
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [p_num_reqs-1:0]             in_val,
   output logic [p_num_reqs-1:0]             in_rdy,
   input  logic [p_num_reqs*p_msg_nbits-1:0] in_msg,
   output logic                              out_val,
   input  logic                              out_rdy,
   output logic [p_msg_nbits-1:0]            out_msg,
   output logic [c_src_nbits-1:0]            out_src,
   output logic                              locked
);

   localparam int c_cnt_nbits = $clog2(p_burst_max + 1);

   typedef enum logic {IDLE, LOCK} state_t;

   state_t                 state, state_n;
   logic [c_src_nbits-1:0] ptr, ptr_n, owner, owner_n, sel, idx, src;
   logic [c_cnt_nbits-1:0] cnt, cnt_n;
   logic                   can_load, any_val, xfer;

   // Explicit wrap at p_num_reqs so non-power-of-two requester counts never index past N-1.
   function automatic logic [c_src_nbits-1:0] wrap_inc(input logic [c_src_nbits-1:0] i);
      if (int'(i) + 1 >= p_num_reqs) return '0;
      return c_src_nbits'(int'(i) + 1);
   endfunction

   assign can_load = ~out_val | out_rdy;
   assign locked   = (state == LOCK);

   always_comb begin
      sel     = ptr;
      any_val = 1'b0;
      idx     = ptr;
      for (int unsigned k = 0; k < p_num_reqs; k++) begin
         if (!any_val && in_val[idx]) begin
            sel     = idx;
            any_val = 1'b1;
         end
         idx = wrap_inc(idx);
      end
   end

   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      owner_n = owner;
      cnt_n   = cnt;
      xfer    = 1'b0;
      src     = ptr;
      in_rdy  = '0;
      unique case (state)
         IDLE: begin
            if (any_val && can_load) begin
               xfer  = 1'b1;
               src   = sel;
               cnt_n = c_cnt_nbits'(1);
               if (p_burst_max > 1) begin
                  state_n = LOCK;
                  owner_n = sel;
               end else begin
                  ptr_n = wrap_inc(sel);
               end
            end
         end
         LOCK: begin
            // A vanished owner releases the lock regardless of backpressure; backpressure alone only holds.
            if (!in_val[owner]) begin
               state_n = IDLE;
               ptr_n   = wrap_inc(owner);
            end else if (can_load) begin
               xfer  = 1'b1;
               src   = owner;
               cnt_n = cnt + 1'b1;
               if (int'(cnt) + 1 >= p_burst_max) begin
                  state_n = IDLE;
                  ptr_n   = wrap_inc(owner);
               end
            end
         end
         default: ;
      endcase
      in_rdy[src] = xfer & reset;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         ptr     <= '0;
         owner   <= '0;
         cnt     <= '0;
         out_val <= 1'b0;
         out_msg <= '0;
         out_src <= '0;
      end else begin
         state <= state_n;
         ptr   <= ptr_n;
         owner <= owner_n;
         cnt   <= cnt_n;
         if (xfer) begin
            out_val <= 1'b1;
            out_msg <= in_msg[int'(src)*p_msg_nbits +: p_msg_nbits];
            out_src <= src;
         end else if (out_rdy) begin
            out_val <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_queue_rr_arbiter.sv
// Bench for queue_rr_arbiter: three instances (N=4/burst=4, N=4/burst=1, N=3/burst=1)
// checked each cycle against a rule-level model plus a per-source in-order scoreboard.
module tb_queue_rr_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  val [3];
   logic        ordy [3];
   logic [31:0] msg_a [3][4];
   logic [3:0]  nxt_val [3];
   logic        nxt_rdy [3];
   logic [127:0] pk0, pk1;
   logic [95:0]  pk2;
   logic [3:0]  rdy0, rdy1;
   logic [2:0]  rdy2;
   logic [3:0]  rw [3];
   logic        ov [3];
   logic [31:0] om [3];
   logic [1:0]  os [3];
   logic        lk [3];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         pk0[i*32 +: 32] = msg_a[0][i];
         pk1[i*32 +: 32] = msg_a[1][i];
      end
      for (int i = 0; i < 3; i++) pk2[i*32 +: 32] = msg_a[2][i];
      rw[0] = rdy0;
      rw[1] = rdy1;
      rw[2] = {1'b0, rdy2};
   end

   queue_rr_arbiter #(.p_num_reqs(4), .p_msg_nbits(32), .p_burst_max(4)) dut0 (
      .clk(clk), .reset(reset), .in_val(val[0]), .in_rdy(rdy0), .in_msg(pk0),
      .out_val(ov[0]), .out_rdy(ordy[0]), .out_msg(om[0]), .out_src(os[0]), .locked(lk[0]));
   queue_rr_arbiter #(.p_num_reqs(4), .p_msg_nbits(32), .p_burst_max(1)) dut1 (
      .clk(clk), .reset(reset), .in_val(val[1]), .in_rdy(rdy1), .in_msg(pk1),
      .out_val(ov[1]), .out_rdy(ordy[1]), .out_msg(om[1]), .out_src(os[1]), .locked(lk[1]));
   queue_rr_arbiter #(.p_num_reqs(3), .p_msg_nbits(32), .p_burst_max(1)) dut2 (
      .clk(clk), .reset(reset), .in_val(val[2][2:0]), .in_rdy(rdy2), .in_msg(pk2),
      .out_val(ov[2]), .out_rdy(ordy[2]), .out_msg(om[2]), .out_src(os[2]), .locked(lk[2]));

   // Reference model: rule-level arbitration state per instance
   int          mn [3] = '{4, 4, 3};
   int          mb [3] = '{4, 1, 1};
   int          m_ptr [3], m_own [3], m_cnt [3], m_osrc [3];
   bit          m_lock [3], m_oval [3];
   logic [31:0] m_omsg [3];
   int          seq [3][4];
   logic [31:0] sent_q [12][$];
   int          hist [3][$];
   bit [3:0]    last_rdy [3];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_ptr[k] = 0; m_own[k] = 0; m_cnt[k] = 0; m_osrc[k] = 0;
         m_lock[k] = 0; m_oval[k] = 0; m_omsg[k] = '0; last_rdy[k] = '0;
         hist[k].delete();
      end
      for (int q = 0; q < 12; q++) sent_q[q].delete();
   endtask

   task automatic model_step(input int k, output bit [3:0] er);
      bit can;
      int src;
      can = !m_oval[k] || ordy[k];
      src = -1;
      er  = '0;
      if (!m_lock[k]) begin
         for (int t = 0; t < mn[k]; t++) begin
            int j;
            j = (m_ptr[k] + t) % mn[k];
            if (src < 0 && val[k][j]) src = j;
         end
         if (src >= 0 && can) begin
            er[src]  = 1'b1;
            m_cnt[k] = 1;
            if (mb[k] > 1) begin
               m_lock[k] = 1;
               m_own[k]  = src;
            end else begin
               m_ptr[k] = (src + 1) % mn[k];
            end
         end
      end else if (!val[k][m_own[k]]) begin
         m_lock[k] = 0;
         m_ptr[k]  = (m_own[k] + 1) % mn[k];
      end else if (can) begin
         src      = m_own[k];
         er[src]  = 1'b1;
         m_cnt[k] = m_cnt[k] + 1;
         if (m_cnt[k] == mb[k]) begin
            m_lock[k] = 0;
            m_ptr[k]  = (m_own[k] + 1) % mn[k];
         end
      end
      if (er != 0) begin
         m_oval[k] = 1;
         m_omsg[k] = msg_a[k][src];
         m_osrc[k] = src;
      end else if (ordy[k]) begin
         m_oval[k] = 0;
      end
   endtask

   task automatic tick();
      bit [3:0] er;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("d%0d_out_val", k), ov[k], m_oval[k]);
         chk($sformatf("d%0d_out_src", k), os[k], m_osrc[k]);
         chk($sformatf("d%0d_out_msg", k), om[k], m_omsg[k]);
         chk($sformatf("d%0d_locked", k), lk[k], m_lock[k]);
         if (ov[k]) hist[k].push_back(int'(os[k]));
      end
      for (int k = 0; k < 3; k++) begin
         val[k]  = nxt_val[k] & ((k == 2) ? 4'b0111 : 4'b1111);
         ordy[k] = nxt_rdy[k];
         for (int i = 0; i < 4; i++) msg_a[k][i] = {4'(k), 4'(i), 24'(seq[k][i])};
      end
      #1;
      for (int k = 0; k < 3; k++) begin
         if (ov[k] && ordy[k]) begin
            int q;
            q = k*4 + int'(os[k]);
            chk($sformatf("d%0d_sb_nonempty", k), sent_q[q].size() != 0, 1);
            if (sent_q[q].size() != 0) chk($sformatf("d%0d_sb_order", k), om[k], sent_q[q].pop_front());
         end
         model_step(k, er);
         chk($sformatf("d%0d_in_rdy", k), rw[k], er);
         chk($sformatf("d%0d_onehot0", k), $onehot0(rw[k]), 1);
         for (int i = 0; i < 4; i++) begin
            if (er[i]) begin
               sent_q[k*4+i].push_back(msg_a[k][i]);
               seq[k][i]++;
            end
         end
         last_rdy[k] = er;
      end
   endtask

   int e0 [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
   int e1 [6] = '{0, 1, 2, 3, 0, 1};
   int e2 [6] = '{0, 1, 2, 0, 1, 2};
   logic [31:0] held;

   initial begin
      for (int k = 0; k < 3; k++) begin
         val[k] = '0; ordy[k] = 1'b0; nxt_val[k] = '0; nxt_rdy[k] = 1'b0;
         for (int i = 0; i < 4; i++) begin
            seq[k][i] = 0;
            msg_a[k][i] = '0;
         end
      end
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_out_val", ov[0], 0);
      chk("rst_locked", lk[0], 0);
      reset = 1'b1;

      // Burst-4 pair, burst-1 all four, N=3 all three
      nxt_val[0] = 4'b0011; nxt_val[1] = 4'b1111; nxt_val[2] = 4'b0111;
      for (int k = 0; k < 3; k++) nxt_rdy[k] = 1'b1;
      repeat (11) tick();
      chk("hist0_len", hist[0].size() >= 8, 1);
      chk("hist1_len", hist[1].size() >= 6, 1);
      chk("hist2_len", hist[2].size() >= 6, 1);
      for (int j = 0; j < 8; j++) chk($sformatf("seq_b4_%0d", j), hist[0][j], e0[j]);
      for (int j = 0; j < 6; j++) chk($sformatf("seq_n4_%0d", j), hist[1][j], e1[j]);
      for (int j = 0; j < 6; j++) chk($sformatf("seq_n3_%0d", j), hist[2][j], e2[j]);

      // Owner 2 drops after two messages: one bubble, then requester 3
      nxt_val[0] = 4'b0000;
      repeat (2) tick();
      nxt_val[0] = 4'b0100;
      repeat (2) tick();
      nxt_val[0] = 4'b1000;
      tick();
      chk("bubble_rdy", rw[0], 4'b0000);
      chk("bubble_locked", lk[0], 1);
      tick();
      chk("after_bubble_rdy", rw[0], 4'b1000);

      // Backpressure holds mid-burst
      nxt_rdy[0] = 1'b0;
      tick();
      held = om[0];
      for (int j = 0; j < 4; j++) begin
         tick();
         chk("bp_msg_stable", om[0], held);
         chk("bp_rdy", rw[0], 4'b0000);
      end
      nxt_rdy[0] = 1'b1;
      repeat (2) tick();

      // Asynchronous reset mid-burst with a message held
      #2;
      chk("pre_rst_out_val", ov[0], 1);
      reset = 1'b0;
      #1;
      chk("mid_rst_out_val", ov[0], 0);
      chk("mid_rst_locked", lk[0], 0);
      chk("mid_rst_rdy", rw[0], 4'b0000);
      for (int k = 0; k < 3; k++) begin
         val[k] = '0; nxt_val[k] = '0;
      end
      model_reset();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      nxt_val[0] = 4'b1111;
      tick();
      chk("post_rst_grant", rw[0], 4'b0001);

      // Random traffic; a requester holds in_val until accepted
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < 3; k++) begin
            bit [3:0] nv;
            nv = '0;
            for (int i = 0; i < mn[k]; i++)
               nv[i] = (val[k][i] && !last_rdy[k][i]) ? 1'b1 : ($urandom_range(0, 2) != 0);
            nxt_val[k] = nv;
            nxt_rdy[k] = ($urandom_range(0, 3) != 0);
         end
         tick();
      end
      for (int k = 0; k < 3; k++) begin
         nxt_val[k] = '0; nxt_rdy[k] = 1'b1;
      end
      repeat (3) tick();
      for (int q = 0; q < 12; q++) chk($sformatf("sb_drained_%0d", q), sent_q[q].size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
